ir_tx_gen: RTL and testbench

IR_TX_GEN -- requirements
Module: ir_tx_gen

---
 rtl/ir_tx_gen.sv | 183 ++++++++++++++++++
 tb/tb_ir_tx_gen.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/ir_tx_gen.sv
// ----------------------------------------------------------------------------
// ir_tx_gen -- infrared frame transmitter with delta-sigma carrier gating.
//
// A frame of up to FRAME_W unit bits is sent MSB-first, one bit per unit time.
// The unit time is set by rising edges of the asynchronous uck input. While a
// '1' unit is being sent, sdo is the synchronized carrier clock (ock) gated by
// the carry of a delta-sigma accumulator, which sets the carrier density. The
// frame can be repeated, with gap_len silent units between copies.
//
// Ports
//   clk, rst                  system clock, async active-high reset
//   enable                    block enable; low aborts to IDLE without ack
//   ock, uck                  async carrier / unit-time clocks
//   req                       start request (level, sampled in IDLE)
//   frame, frame_len          bit pattern and unit count (clipped to FRAME_W)
//   repeat_cnt, gap_len       extra repetitions, silent units between them
//   dsm_din_ir_tx_carrier_on  carrier density word (used live, not latched)
//   sdo                       registered IR drive
//   busy                      high in every state except IDLE
//   ack                       one-clk pulse while in DONE
// ----------------------------------------------------------------------------
module ir_tx_gen #(
    parameter int FRAME_W = 160,
    parameter int LEN_W   = 8,
    parameter int DSM_W   = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               ock,
    input  logic               uck,
    input  logic               req,
    input  logic [FRAME_W-1:0] frame,
    input  logic [LEN_W-1:0]   frame_len,
    input  logic [3:0]         repeat_cnt,
    input  logic [7:0]         gap_len,
    input  logic [DSM_W-1:0]   dsm_din_ir_tx_carrier_on,
    output logic               sdo,
    output logic               busy,
    output logic               ack
);
    localparam int IDX_W = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
    localparam int LN_W  = $clog2(FRAME_W + 1);

    typedef enum logic [2:0] {IDLE, ALIGN, SEND, GAP, DONE} state_t;

    state_t             r_state;
    logic [1:0]         r_ock_s;
    logic [1:0]         r_uck_s;
    logic               r_uck_d;
    logic [FRAME_W-1:0] r_frame;
    logic [LN_W-1:0]    r_len;
    logic [3:0]         r_rep;
    logic [7:0]         r_gap;
    logic [7:0]         r_gap_cnt;
    logic [IDX_W-1:0]   r_idx;
    logic [DSM_W-1:0]   r_acc;

    logic               w_ock;
    logic               w_uck_rise;
    logic [LN_W-1:0]    w_len_clip;
    logic [IDX_W-1:0]   w_idx_dec;
    logic [IDX_W-1:0]   w_idx_reload;
    logic [DSM_W:0]     w_sum;
    logic               w_carry;

    assign w_ock        = r_ock_s[1];
    assign w_uck_rise   = r_uck_s[1] & ~r_uck_d;
    assign w_idx_dec    = r_idx - 1'b1;
    assign w_idx_reload = IDX_W'(r_len - 1'b1);
    assign w_sum        = {1'b0, r_acc} + {1'b0, dsm_din_ir_tx_carrier_on};
    assign w_carry      = w_sum[DSM_W];

    // Lengths beyond the buffer are clipped to the buffer width.
    always_comb begin
        if (32'(frame_len) > 32'(FRAME_W))
            w_len_clip = LN_W'(FRAME_W);
        else
            w_len_clip = LN_W'(frame_len);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_ock_s   <= '0;
            r_uck_s   <= '0;
            r_uck_d   <= 1'b0;
            r_frame   <= '0;
            r_len     <= '0;
            r_rep     <= '0;
            r_gap     <= '0;
            r_gap_cnt <= '0;
            r_idx     <= '0;
            r_acc     <= '0;
            sdo       <= 1'b0;
            busy      <= 1'b0;
            ack       <= 1'b0;
        end else begin
            r_ock_s <= {r_ock_s[0], ock};
            r_uck_s <= {r_uck_s[0], uck};
            r_uck_d <= r_uck_s[1];
            sdo     <= 1'b0;
            ack     <= 1'b0;

            if (!enable) begin
                r_state <= IDLE;
                busy    <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (req) begin
                            r_frame <= frame;
                            r_len   <= w_len_clip;
                            r_rep   <= repeat_cnt;
                            r_gap   <= gap_len;
                            r_acc   <= '0;
                            busy    <= 1'b1;
                            if (w_len_clip == '0) begin
                                r_state <= DONE;
                                ack     <= 1'b1;
                            end else begin
                                r_state <= ALIGN;
                            end
                        end
                    end

                    ALIGN: begin
                        if (w_uck_rise) begin
                            r_idx   <= w_idx_reload;
                            r_state <= SEND;
                        end
                    end

                    SEND: begin
                        r_acc <= w_sum[DSM_W-1:0];
                        // On a unit boundary sdo already follows the new bit.
                        if (w_uck_rise) begin
                            if (r_idx != '0) begin
                                r_idx <= w_idx_dec;
                                sdo   <= r_frame[w_idx_dec] & w_ock & w_carry;
                            end else if (r_rep != '0) begin
                                r_rep <= r_rep - 1'b1;
                                if (r_gap == '0) begin
                                    r_idx <= w_idx_reload;
                                    sdo   <= r_frame[w_idx_reload] & w_ock & w_carry;
                                end else begin
                                    r_gap_cnt <= r_gap;
                                    r_state   <= GAP;
                                end
                            end else begin
                                r_state <= DONE;
                                ack     <= 1'b1;
                            end
                        end else begin
                            sdo <= r_frame[r_idx] & w_ock & w_carry;
                        end
                    end

                    GAP: begin
                        if (w_uck_rise) begin
                            if (r_gap_cnt == 8'd1) begin
                                r_idx   <= w_idx_reload;
                                r_state <= SEND;
                            end else begin
                                r_gap_cnt <= r_gap_cnt - 1'b1;
                            end
                        end
                    end

                    DONE: begin
                        r_state <= IDLE;
                        busy    <= 1'b0;
                    end

                    default: begin
                        r_state <= IDLE;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ir_tx_gen.sv
module tb_ir_tx_gen;
    logic         clk, rst, enable, ock, uck, req;
    logic [159:0] frame;
    logic [7:0]   frame_len;
    logic [3:0]   repeat_cnt;
    logic [7:0]   gap_len;
    logic [31:0]  din;
    logic         sdo, busy, ack;

    int errors = 0;
    int checks = 0;
    int ack_cnt = 0;
    int ock_mode = 1;   // 0: low, 1: toggling, 2: held high

    ir_tx_gen dut (
        .clk(clk), .rst(rst), .enable(enable), .ock(ock), .uck(uck), .req(req),
        .frame(frame), .frame_len(frame_len), .repeat_cnt(repeat_cnt),
        .gap_len(gap_len), .dsm_din_ir_tx_carrier_on(din),
        .sdo(sdo), .busy(busy), .ack(ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        ock = 1'b0;
        forever begin
            #37;
            case (ock_mode)
                0:       ock = 1'b0;
                1:       ock = ~ock;
                default: ock = 1'b1;
            endcase
        end
    end

    always @(negedge clk) if (ack) ack_cnt++;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic [159:0] frame;
        logic [7:0]   len;
        logic [3:0]   rep;
        logic [7:0]   gap;
        logic [31:0]  din;
        int           units;
        logic [63:0]  exp_act;   // bit u: unit u+1 shows carrier bursts
    } vec_t;

    vec_t vt[5];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One unit time: uck rise, 20 clk high, 20 clk low. Counts sdo highs after
    // the synchronizer/register latency has settled.
    task automatic unit_cycle(output int hi);
        hi = 0;
        uck = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 20) uck = 1'b0;
            if (i >= 6) hi += int'(sdo);
        end
    endtask

    // Issue a request, then scramble the latched inputs to prove they are held.
    task automatic start_frame(input logic [159:0] f, input logic [7:0] l,
                               input logic [3:0] r, input logic [7:0] g,
                               input logic [31:0] d);
        frame = f; frame_len = l; repeat_cnt = r; gap_len = g; din = d;
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        frame = ~f; frame_len = 8'd3; repeat_cnt = 4'd15; gap_len = 8'd1;
    endtask

    task automatic finish_frame(input string nm, input int base);
        chk({nm, " no early ack"}, ack_cnt, base);
        uck = 1'b1;
        repeat (6) @(negedge clk);
        chk({nm, " one ack"}, ack_cnt, base + 1);
        chk({nm, " busy clear"}, busy, 0);
        uck = 1'b0;
        repeat (20) @(negedge clk);
    endtask

    task automatic run_vec(input string nm, input vec_t v);
        int base, hi;
        logic [63:0] act;
        base = ack_cnt;
        act = '0;
        start_frame(v.frame, v.len, v.rep, v.gap, v.din);
        chk({nm, " busy"}, busy, 1);
        repeat (4) @(negedge clk);
        chk({nm, " align quiet"}, sdo, 0);
        for (int u = 0; u < v.units; u++) begin
            unit_cycle(hi);
            act[u] = (hi > 0);
            if (u == 0) begin
                // request while busy must be ignored
                req = 1'b1;
                repeat (2) @(negedge clk);
                req = 1'b0;
            end
        end
        chk({nm, " unit pattern"}, act, v.exp_act);
        finish_frame(nm, base);
    endtask

    initial begin
        int base, hi, err, tog;
        logic prev;
        logic [159:0] lf;

        vt[0] = '{160'hF5A, 8'd8, 4'd0, 8'd0, 32'h553f7d00, 8,  64'h5A};
        vt[1] = '{160'hF,   8'd4, 4'd2, 8'd3, 32'h80000000, 18, 64'h3C78F};
        vt[2] = '{160'h5,   8'd3, 4'd1, 8'd0, 32'h80000000, 6,  64'h2D};
        vt[3] = '{160'h13,  8'd5, 4'd0, 8'd0, 32'hFFFFFFFF, 5,  64'h19};
        vt[4] = '{160'hFF,  8'd8, 4'd0, 8'd0, 32'h00000000, 8,  64'h0};

        rst = 1'b1; enable = 1'b1; uck = 1'b0; req = 1'b0;
        frame = '0; frame_len = '0; repeat_cnt = '0; gap_len = '0; din = '0;
        repeat (3) @(negedge clk);
        chk("reset sdo", sdo, 0);
        chk("reset busy", busy, 0);
        chk("reset ack", ack, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        for (int k = 0; k < 5; k++) run_vec($sformatf("vec%0d", k), vt[k]);

        // zero length: straight to DONE, one ack, busy for one clk
        base = ack_cnt;
        frame = '1; frame_len = 8'd0; din = 32'h80000000;
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        chk("len0 busy", busy, 1);
        chk("len0 ack", ack, 1);
        chk("len0 sdo", sdo, 0);
        @(negedge clk);
        chk("len0 busy drop", busy, 0);
        chk("len0 ack count", ack_cnt, base + 1);
        repeat (3) @(negedge clk);

        // oversize length clipped to 160 units, MSB first over the whole buffer
        base = ack_cnt;
        lf = {5{32'hA5C30F96}};
        start_frame(lf, 8'd255, 4'd0, 8'd0, 32'h80000000);
        err = 0;
        for (int u = 0; u < 160; u++) begin
            unit_cycle(hi);
            if ((hi > 0) != lf[159 - u]) err++;
        end
        chk("len255 pattern errors", err, 0);
        finish_frame("len255", base);

        // enable dropped mid-SEND
        base = ack_cnt;
        start_frame(160'hFF, 8'd8, 4'd0, 8'd0, 32'h80000000);
        for (int u = 0; u < 3; u++) unit_cycle(hi);
        uck = 1'b1;
        repeat (8) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        chk("en drop busy", busy, 0);
        chk("en drop sdo", sdo, 0);
        enable = 1'b1;
        repeat (30) @(negedge clk);
        uck = 1'b0;
        repeat (20) @(negedge clk);
        chk("en drop no ack", ack_cnt, base);
        chk("en drop sdo idle", sdo, 0);
        run_vec("after en drop", vt[0]);

        // async reset mid-frame
        base = ack_cnt;
        start_frame(160'hFF, 8'd8, 4'd0, 8'd0, 32'h80000000);
        for (int u = 0; u < 2; u++) unit_cycle(hi);
        uck = 1'b1;
        repeat (8) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst mid busy", busy, 0);
        chk("rst mid sdo", sdo, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        uck = 1'b0;
        repeat (20) @(negedge clk);
        chk("rst mid no ack", ack_cnt, base);
        run_vec("after rst", vt[2]);

        // half-density carrier with ock held high: sdo alternates every clk
        ock_mode = 2;
        repeat (10) @(negedge clk);
        start_frame(160'hFF, 8'd8, 4'd0, 8'd0, 32'h80000000);
        unit_cycle(hi);
        uck = 1'b1;
        repeat (8) @(negedge clk);
        prev = sdo;
        tog = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (sdo != prev) tog++;
            prev = sdo;
        end
        chk("half density toggles", tog, 10);
        din = 32'h0;
        repeat (3) @(negedge clk);
        hi = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            hi += int'(sdo);
        end
        chk("zero density silent", hi, 0);
        uck = 1'b0;
        enable = 1'b0;
        @(negedge clk);
        enable = 1'b1;
        ock_mode = 1;
        repeat (20) @(negedge clk);
        chk("final idle busy", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
